// File: rtl/op_demux_pkg.sv
// op_demux_pkg: path-select codes and slot state encoding shared by the operand demux and the ALU result mux.
package op_demux_pkg;
  localparam logic SEL_ADD = 1'b0;
  localparam logic SEL_NOT = 1'b1;
  typedef enum logic {SLOT_EMPTY = 1'b0, SLOT_FULL = 1'b1} slot_state_e;
endpackage

// File: rtl/op_demux_slot.sv
// demux_slot: one-entry register slice with load, drain, flush and synchronous reset.
module demux_slot
  import op_demux_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         load,
  input  logic [N-1:0] load_data,
  input  logic         ready,
  output logic         valid,
  output logic [N-1:0] data
);
  slot_state_e  state_q, state_d;
  logic [N-1:0] data_q, data_d;
  // a load into a full slot only happens alongside a drain, so it simply overwrites
  always_comb begin
    state_d = flush ? SLOT_EMPTY :
              load ? SLOT_FULL :
              (state_q == SLOT_FULL && ready) ? SLOT_EMPTY : state_q;
    data_d  = (load && !flush) ? load_data : data_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end
  assign valid = (state_q == SLOT_FULL);
  assign data  = data_q;
endmodule

// File: rtl/op_demux.sv
// op_demux: registered 1-to-2 operand demux (ADD/NOT paths); OP_DEMUX_STATS_EN builds per-path accept counters.
module op_demux
  import op_demux_pkg::*;
#(
  parameter int N  = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic [N-1:0]  in_data,
  input  logic          in_select,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [N-1:0]  out0_data,
  output logic          out0_valid,
  input  logic          out0_ready,
  output logic [N-1:0]  out1_data,
  output logic          out1_valid,
  input  logic          out1_ready,
  output logic [CW-1:0] count0,
  output logic [CW-1:0] count1
);
  logic accept, load0, load1;
  always_comb begin
    in_ready = (in_select == SEL_NOT) ? (!out1_valid || out1_ready) : (!out0_valid || out0_ready);
    accept   = in_valid && in_ready;
    load0    = accept && (in_select == SEL_ADD);
    load1    = accept && (in_select == SEL_NOT);
  end
  demux_slot #(.N(N)) u_slot0 (
    .clk(clk), .rst(rst), .flush(flush), .load(load0), .load_data(in_data),
    .ready(out0_ready), .valid(out0_valid), .data(out0_data)
  );
  demux_slot #(.N(N)) u_slot1 (
    .clk(clk), .rst(rst), .flush(flush), .load(load1), .load_data(in_data),
    .ready(out1_ready), .valid(out1_valid), .data(out1_data)
  );
`ifdef OP_DEMUX_STATS_EN
  logic [CW-1:0] count0_q, count0_d, count1_q, count1_d;
  // an accept discarded by flush is not counted
  always_comb begin
    count0_d = count0_q + CW'(load0 && !flush);
    count1_d = count1_q + CW'(load1 && !flush);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      count0_q <= '0;
      count1_q <= '0;
    end else begin
      count0_q <= count0_d;
      count1_q <= count1_d;
    end
  end
  assign count0 = count0_q;
  assign count1 = count1_q;
`else
  assign count0 = '0;
  assign count1 = '0;
`endif
endmodule

// File: tb/tb_op_demux.sv
// tb_op_demux: vector table plus scoreboard queues checking steering, backpressure, flush, reset and counters.
module tb_op_demux;
  localparam int N = 32, CW = 4;
  logic clk = 0, rst, flush, in_select, in_valid, in_ready;
  logic out0_valid, out0_ready, out1_valid, out1_ready;
  logic [N-1:0] in_data, out0_data, out1_data;
  logic [CW-1:0] count0, count1;
  int n_vec = 0, n_err = 0;
  logic [N-1:0] q0[$], q1[$];
  logic f0 = 0, f1 = 0, k0 = 1, k1 = 1;
  logic [N-1:0] l0 = 0, l1 = 0;
  logic [CW-1:0] c0 = 0, c1 = 0;
  typedef struct {
    logic v, s;
    logic [N-1:0] d;
    logic r0, r1, fl, rs, er;
  } vec_t;
  vec_t vt[17];

  op_demux #(.N(N), .CW(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_data(in_data), .in_select(in_select),
    .in_valid(in_valid), .in_ready(in_ready), .out0_data(out0_data), .out0_valid(out0_valid),
    .out0_ready(out0_ready), .out1_data(out1_data), .out1_valid(out1_valid),
    .out1_ready(out1_ready), .count0(count0), .count1(count1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [N-1:0] a, input logic [N-1:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  task automatic step(input logic v, s, input logic [N-1:0] d, input logic r0, r1, fl, rs,
                      input int er);
    logic mr;
    logic [CW-1:0] e0, e1;
    in_valid = v; in_select = s; in_data = d;
    out0_ready = r0; out1_ready = r1; flush = fl; rst = rs;
    #1;
    mr = s ? (!f1 || r1) : (!f0 || r0);
    chk("in_ready", {31'b0, in_ready}, {31'b0, mr});
    if (er >= 0) chk("in_ready_tbl", {31'b0, in_ready}, {31'b0, er[0]});
    chk("out0_valid", {31'b0, out0_valid}, {31'b0, f0});
    chk("out1_valid", {31'b0, out1_valid}, {31'b0, f1});
    if (f0) chk("out0_data", out0_data, q0[0]); else if (k0) chk("out0_hold", out0_data, l0);
    if (f1) chk("out1_data", out1_data, q1[0]); else if (k1) chk("out1_hold", out1_data, l1);
`ifdef OP_DEMUX_STATS_EN
    e0 = c0; e1 = c1;
`else
    e0 = '0; e1 = '0;
`endif
    chk("count0", {28'b0, count0}, {28'b0, e0});
    chk("count1", {28'b0, count1}, {28'b0, e1});
    @(posedge clk);
    if (rs) begin
      q0.delete(); q1.delete();
      f0 = 0; f1 = 0; k0 = 1; k1 = 1; l0 = 0; l1 = 0; c0 = 0; c1 = 0;
    end else if (fl) begin
      q0.delete(); q1.delete();
      f0 = 0; f1 = 0; k0 = 0; k1 = 0;
    end else begin
      if (f0 && r0) begin void'(q0.pop_front()); f0 = 0; end
      if (f1 && r1) begin void'(q1.pop_front()); f1 = 0; end
      if (v && mr) begin
        if (s) begin q1.push_back(d); f1 = 1; k1 = 1; l1 = d; c1++; end
        else begin q0.push_back(d); f0 = 1; k0 = 1; l0 = d; c0++; end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    vt[0]  = '{1, 0, 32'h77,       1, 1, 0, 1, 1};
    vt[1]  = '{1, 0, 32'h5,        1, 1, 0, 0, 1};
    vt[2]  = '{1, 1, 32'hFFFFFFFB, 1, 1, 0, 0, 1};
    vt[3]  = '{0, 0, 32'h0,        1, 1, 0, 0, 1};
    vt[4]  = '{1, 0, 32'hA,        0, 1, 0, 0, 1};
    vt[5]  = '{1, 0, 32'hB,        0, 1, 0, 0, 0};
    vt[6]  = '{1, 1, 32'hC,        0, 0, 0, 0, 1};
    vt[7]  = '{1, 0, 32'hB,        1, 0, 0, 0, 1};
    vt[8]  = '{0, 0, 32'h0,        1, 1, 0, 0, 1};
    vt[9]  = '{1, 0, 32'h11,       0, 0, 0, 0, 1};
    vt[10] = '{1, 1, 32'h22,       0, 0, 0, 0, 1};
    vt[11] = '{1, 0, 32'h33,       1, 0, 1, 0, 1};
    vt[12] = '{0, 0, 32'h0,        1, 1, 0, 0, 1};
    vt[13] = '{1, 0, 32'h44,       0, 0, 0, 0, 1};
    vt[14] = '{1, 1, 32'h55,       0, 0, 0, 0, 1};
    vt[15] = '{1, 1, 32'h66,       0, 0, 0, 1, 0};
    vt[16] = '{0, 0, 32'h0,        1, 1, 0, 0, 1};
    rst = 1; flush = 0; in_valid = 1; in_select = 0; in_data = 32'h99;
    out0_ready = 1; out1_ready = 1;
    @(posedge clk);
    @(negedge clk);
    foreach (vt[i])
      step(vt[i].v, vt[i].s, vt[i].d, vt[i].r0, vt[i].r1, vt[i].fl, vt[i].rs, int'(vt[i].er));
    for (int i = 0; i < 8; i++) step(1, 0, 32'h1000 + i, 1, 1, 0, 0, 1);
    step(0, 0, 0, 1, 1, 0, 0, 1);
    for (int i = 0; i < 17; i++) step(1, 1, 32'h8000_0000 + i, 1, 1, 0, 0, 1);
    step(0, 1, 0, 1, 1, 0, 0, 1);
    step(0, 0, 0, 1, 1, 0, 0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
